crc8_arbiter: RTL and testbench

//  Shares one bit-serial CRC-8 engine (poly x^8+x^2+x+1, LSB of 16-bit word first) among N_REQ requesters.

---
 rtl/crc8_arbiter.sv | 166 ++++++++++++++++
 tb/tb_crc8_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_arbiter.sv
// Round-robin arbiter that shares one bit-serial CRC-8 engine among N_REQ clients.
// Define CRC8_ARB_TIMEOUT_EN to add a WAIT-state watchdog that aborts a hung engine.
module crc8_arbiter #(
   parameter int         N_REQ          = 4,
   parameter logic [7:0] INIT_VAL       = 8'h00,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_REQ-1:0]    req_i,
   input  logic [16*N_REQ-1:0] data_i,
   output logic [N_REQ-1:0]    gnt_o,
   output logic [N_REQ-1:0]    done_o,
   output logic [7:0]          crc_o,
   output logic                err_o,
   output logic                busy_o,
   output logic                eng_rst_o,
   output logic [7:0]          eng_init_o,
   output logic [15:0]         eng_val_o,
   output logic                eng_start_o,
   input  logic                eng_busy_i,
   input  logic [7:0]          eng_result_i
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
      $error("crc8_arbiter: N_REQ or TIMEOUT_CYCLES out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [N_REQ-1:0] gnt_q;
   logic [N_REQ-1:0] done_q;
   logic [IDX_W-1:0] rr_q;
   logic [7:0]       crc_q;
   logic [15:0]      val_q;
   logic             eng_rst_q;
   logic             eng_start_q;
   logic             seen_busy_q;
`ifdef CRC8_ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]       timer_q;
   logic             err_q;
`endif

   logic [IDX_W-1:0] cand_c;
   logic             win_found_d;
   logic [IDX_W-1:0] win_idx_d;
   logic [15:0]      win_word_d;
   logic [N_REQ-1:0] win_gnt_d;

   // Scan clients starting just after the last winner, wrapping, so the last winner ranks lowest.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      cand_c      = '0;
      win_found_d = 1'b0;
      win_idx_d   = rr_q;
      win_word_d  = '0;
      win_gnt_d   = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand_c = IDX_W'((int'(rr_q) + off) % N_REQ);
         if (!win_found_d && req_i[cand_c]) begin
            win_found_d       = 1'b1;
            win_idx_d         = cand_c;
            win_word_d        = data_i[{cand_c, 4'b0000} +: 16];
            win_gnt_d[cand_c] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         gnt_q       <= '0;
         done_q      <= '0;
         rr_q        <= IDX_W'(N_REQ - 1);
         crc_q       <= '0;
         val_q       <= '0;
         eng_rst_q   <= 1'b0;
         eng_start_q <= 1'b0;
         seen_busy_q <= 1'b0;
`ifdef CRC8_ARB_TIMEOUT_EN
         timer_q     <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
         done_q      <= '0;
         eng_rst_q   <= 1'b0;
         eng_start_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (win_found_d) begin
                  gnt_q     <= win_gnt_d;
                  val_q     <= win_word_d;
                  rr_q      <= win_idx_d;
                  eng_rst_q <= 1'b1;
                  state_q   <= S_LOAD;
               end
            end
            S_LOAD: begin
               eng_start_q <= 1'b1;
               state_q     <= S_START;
            end
            S_START: begin
               seen_busy_q <= 1'b0;
`ifdef CRC8_ARB_TIMEOUT_EN
               timer_q     <= '0;
`endif
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               // The engine may take a cycle to raise busy; only a busy-then-idle sequence means done.
               if (eng_busy_i) seen_busy_q <= 1'b1;
               if (!eng_busy_i && seen_busy_q) begin
                  done_q  <= gnt_q;
                  crc_q   <= eng_result_i;
`ifdef CRC8_ARB_TIMEOUT_EN
                  err_q   <= 1'b0;
`endif
                  state_q <= S_DONE;
               end
`ifdef CRC8_ARB_TIMEOUT_EN
               else if (timer_q == TIMEOUT_LIMIT) begin
                  done_q    <= gnt_q;
                  crc_q     <= '0;
                  err_q     <= 1'b1;
                  eng_rst_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
`endif
            end
            S_DONE: begin
               gnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign crc_o       = crc_q;
   assign busy_o      = (state_q != S_IDLE);
   assign eng_rst_o   = eng_rst_q;
   assign eng_init_o  = INIT_VAL;
   assign eng_val_o   = val_q;
   assign eng_start_o = eng_start_q;
`ifdef CRC8_ARB_TIMEOUT_EN
   assign err_o       = err_q;
`else
   assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_crc8_arbiter.sv
// Bench for crc8_arbiter: behavioural CRC-8 engine plus table-driven and sequence checks.
// Timeout sequence runs only when CRC8_ARB_TIMEOUT_EN is defined.
module tb_crc8_arbiter;

   localparam int N_REQ    = 4;
   localparam int ENG_BUSY = 33;
   localparam int LAT      = 4 + ENG_BUSY;

   logic                clk_i  = 1'b0;
   logic                rst_ni = 1'b0;
   logic [N_REQ-1:0]    req_i  = '0;
   logic [16*N_REQ-1:0] data_i = '0;
   logic [N_REQ-1:0]    gnt_o;
   logic [N_REQ-1:0]    done_o;
   logic [7:0]          crc_o;
   logic                err_o;
   logic                busy_o;
   logic                eng_rst_o;
   logic [7:0]          eng_init_o;
   logic [15:0]         eng_val_o;
   logic                eng_start_o;
   logic                eng_busy_i;
   logic [7:0]          eng_result_i;

   int   total = 0;
   int   bad   = 0;
   logic stuck = 1'b0;

   crc8_arbiter #(
      .N_REQ          (N_REQ),
      .INIT_VAL       (8'h00),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req_i),
      .data_i       (data_i),
      .gnt_o        (gnt_o),
      .done_o       (done_o),
      .crc_o        (crc_o),
      .err_o        (err_o),
      .busy_o       (busy_o),
      .eng_rst_o    (eng_rst_o),
      .eng_init_o   (eng_init_o),
      .eng_val_o    (eng_val_o),
      .eng_start_o  (eng_start_o),
      .eng_busy_i   (eng_busy_i),
      .eng_result_i (eng_result_i)
   );

   always #5 clk_i = ~clk_i;

   // Engine model: start is registered, busy rises one cycle later and lasts ENG_BUSY cycles.
   logic       m_busy;
   logic       m_pend;
   logic [7:0] m_crc;
   int         m_cnt;

   function automatic logic [7:0] crc_word(input logic [7:0] seed, input logic [15:0] w);
      logic [7:0] c = seed;
      for (int i = 0; i < 16; i++) c = {c[6:0], w[i]} ^ (c[7] ? 8'h07 : 8'h00);
      return c;
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_busy <= 1'b0;
         m_pend <= 1'b0;
         m_crc  <= '0;
         m_cnt  <= 0;
      end else if (eng_rst_o) begin
         m_busy <= 1'b0;
         m_pend <= 1'b0;
         m_crc  <= eng_init_o;
         m_cnt  <= 0;
      end else begin
         if (eng_start_o) m_pend <= 1'b1;
         if (m_pend) begin
            m_pend <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= ENG_BUSY;
         end else if (m_busy && !stuck) begin
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_crc  <= crc_word(m_crc, eng_val_o);
            end
            m_cnt <= m_cnt - 1;
         end
      end
   end

   assign eng_busy_i   = m_busy;
   assign eng_result_i = m_crc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_grant(output logic [N_REQ-1:0] g);
      int n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (gnt_o == '0 && n < 200);
      total++;
      if (gnt_o == '0) begin
         bad++;
         $display("FAIL grant_wait: no grant within %0d cycles", n);
      end
      g = gnt_o;
   endtask

   task automatic wait_done(output int lat, output int starts);
      lat    = 0;
      starts = 0;
      while (done_o == '0 && lat < 300) begin
         @(negedge clk_i);
         lat++;
         if (eng_start_o) starts++;
      end
      total++;
      if (done_o == '0) begin
         bad++;
         $display("FAIL done_wait: no done within %0d cycles", lat);
      end
   endtask

   task automatic reset_dut();
      rst_ni = 1'b0;
      req_i  = '0;
      data_i = '0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   typedef struct {
      logic [N_REQ-1:0] req;
      int               client;
      logic [15:0]      word;
      logic [7:0]       crc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [N_REQ-1:0] g;
      int               lat;
      int               starts;
      int               dones;
      logic [7:0]       exp_crc3[4];
      int               order4[4];
      logic [7:0]       crc4[4];

      // Expected CRCs: x^8+x^2+x+1, data bit 0 shifted in first, seed 0.
      vecs[0] = '{4'b0001, 0, 16'h0001, 8'h89};
      vecs[1] = '{4'b0001, 0, 16'h0000, 8'h00};
      vecs[2] = '{4'b0100, 2, 16'h0002, 8'hC7};
      vecs[3] = '{4'b1000, 3, 16'h0100, 8'h80};
      vecs[4] = '{4'b0010, 1, 16'h8000, 8'h01};
      vecs[5] = '{4'b0001, 0, 16'h0003, 8'h4E};
      exp_crc3 = '{8'h89, 8'hC7, 8'h80, 8'h01};
      order4   = '{1, 2, 1, 2};
      crc4     = '{8'h4E, 8'hC7, 8'h4E, 8'hC7};

      // Reset state
      reset_dut();
      check("rst.gnt", gnt_o, 0);
      check("rst.done", done_o, 0);
      check("rst.crc", crc_o, 0);
      check("rst.err", err_o, 0);
      check("rst.busy", busy_o, 0);
      check("rst.eng_rst", eng_rst_o, 0);
      check("rst.eng_start", eng_start_o, 0);
      check("rst.eng_val", eng_val_o, 0);
      check("rst.eng_init", eng_init_o, 8'h00);

      // Single-client vectors
      for (int i = 0; i < 6; i++) begin
         data_i = {N_REQ{~vecs[i].word}};
         data_i[vecs[i].client*16 +: 16] = vecs[i].word;
         req_i = vecs[i].req;
         wait_grant(g);
         check($sformatf("v%0d.gnt", i), g, vecs[i].req);
         check($sformatf("v%0d.eng_val", i), eng_val_o, vecs[i].word);
         check($sformatf("v%0d.eng_rst", i), eng_rst_o, 1);
         check($sformatf("v%0d.busy", i), busy_o, 1);
         data_i = ~data_i;
         wait_done(lat, starts);
         check($sformatf("v%0d.done", i), done_o, vecs[i].req);
         check($sformatf("v%0d.gnt_at_done", i), gnt_o, vecs[i].req);
         check($sformatf("v%0d.latency", i), lat, LAT);
         check($sformatf("v%0d.starts", i), starts, 1);
         check($sformatf("v%0d.crc", i), crc_o, vecs[i].crc);
         check($sformatf("v%0d.err", i), err_o, 0);
         req_i = '0;
         @(negedge clk_i);
         check($sformatf("v%0d.done_clr", i), done_o, 0);
         check($sformatf("v%0d.gnt_drop", i), gnt_o, 0);
         check($sformatf("v%0d.crc_hold", i), crc_o, vecs[i].crc);
         check($sformatf("v%0d.idle", i), busy_o, 0);
      end

      // All four request at once from reset: served 0,1,2,3
      reset_dut();
      data_i = {16'h8000, 16'h0100, 16'h0002, 16'h0001};
      req_i  = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g);
         check($sformatf("rr4.gnt%0d", k), g, 32'd1 << k);
         wait_done(lat, starts);
         check($sformatf("rr4.done%0d", k), done_o, 32'd1 << k);
         check($sformatf("rr4.crc%0d", k), crc_o, exp_crc3[k]);
         req_i[k] = 1'b0;
      end
      @(negedge clk_i);

      // Clients 1 and 2 held high: alternate, one start pulse each
      data_i = {16'h0000, 16'h0002, 16'h0003, 16'h0000};
      req_i  = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g);
         check($sformatf("alt.gnt%0d", k), g, 32'd1 << order4[k]);
         wait_done(lat, starts);
         check($sformatf("alt.starts%0d", k), starts, 1);
         check($sformatf("alt.done%0d", k), done_o, 32'd1 << order4[k]);
         check($sformatf("alt.crc%0d", k), crc_o, crc4[k]);
      end
      req_i = '0;
      @(negedge clk_i);

      // Reset mid-clock while client 2 is in WAIT
      reset_dut();
      data_i = {16'h0000, 16'h0002, 16'h0000, 16'h0100};
      req_i  = 4'b0100;
      wait_grant(g);
      check("abort.gnt", g, 4'b0100);
      repeat (10) @(negedge clk_i);
      @(posedge clk_i);
      #3;
      rst_ni = 1'b0;
      #1;
      check("abort.gnt0", gnt_o, 0);
      check("abort.done0", done_o, 0);
      check("abort.busy0", busy_o, 0);
      check("abort.crc0", crc_o, 0);
      check("abort.eng_val0", eng_val_o, 0);
      check("abort.eng_rst0", eng_rst_o, 0);
      check("abort.eng_start0", eng_start_o, 0);
      req_i = '0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      dones  = 0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk_i);
         if (done_o != '0) dones++;
      end
      check("abort.no_done", dones, 0);
      req_i = 4'b0101;
      wait_grant(g);
      check("abort.next_gnt", g, 4'b0001);
      wait_done(lat, starts);
      check("abort.next_crc", crc_o, 8'h80);
      req_i[0] = 1'b0;
      wait_grant(g);
      check("abort.then_gnt", g, 4'b0100);
      wait_done(lat, starts);
      check("abort.then_crc", crc_o, 8'hC7);
      req_i = '0;
      @(negedge clk_i);

`ifdef CRC8_ARB_TIMEOUT_EN
      // Engine never drops busy: watchdog fires after 64 WAIT cycles
      stuck  = 1'b1;
      data_i = {16'h0000, 16'h0000, 16'h1234, 16'h0001};
      req_i  = 4'b0010;
      wait_grant(g);
      wait_done(lat, starts);
      check("tmo.latency", lat, 2 + 64);
      check("tmo.done", done_o, 4'b0010);
      check("tmo.err", err_o, 1);
      check("tmo.crc", crc_o, 0);
      check("tmo.eng_rst", eng_rst_o, 1);
      req_i = '0;
      stuck = 1'b0;
      @(negedge clk_i);
      req_i = 4'b0001;
      wait_grant(g);
      wait_done(lat, starts);
      check("tmo.recover_crc", crc_o, 8'h89);
      check("tmo.recover_err", err_o, 0);
      req_i = '0;
      @(negedge clk_i);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
